// File: rtl/fc_par_pkg.sv
// Shared state encoding and arithmetic helpers for the parallel FC engine.
package fc_par_pkg;

  typedef logic [1:0] state_t;
  localparam state_t ST_LOAD    = 2'd0;
  localparam state_t ST_COMPUTE = 2'd1;
  localparam state_t ST_DRAIN   = 2'd2;

  // Wide enough for N products of two T-bit values without overflow.
  function automatic int acc_w(input int t, input int n);
    return 2 * t + $clog2(n);
  endfunction

  function automatic logic signed [63:0] sat_t(input logic signed [63:0] acc, input int t);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (t - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (t - 1));
    if (acc > hi) return hi;
    if (acc < lo) return lo;
    return acc;
  endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// One MAC lane: signed multiply, wide accumulator, saturating (optionally ReLU) result register.
module fc_mac_lane
  import fc_par_pkg::*;
#(
  parameter int T    = 16,
  parameter int N    = 8,
  parameter int RELU = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [T-1:0] x,
  input  logic signed [T-1:0] w,
  input  logic                en,
  input  logic                clr,
  input  logic                last,
  output logic signed [T-1:0] result
);

  localparam int AW = acc_w(T, N);

  logic signed [2*T-1:0] prod;
  logic signed [AW-1:0]  acc_reg;
  logic signed [AW-1:0]  acc_next;
  logic signed [63:0]    sat_val;

  // The result register captures the final sum in the same cycle it is formed.
  always_comb begin
    prod     = x * w;
    acc_next = clr ? AW'(prod) : acc_reg + AW'(prod);
    sat_val  = sat_t(64'(acc_next), T);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_reg <= '0;
      result  <= '0;
    end else if (en) begin
      acc_reg <= acc_next;
      if (last) result <= (RELU != 0 && sat_val < 0) ? '0 : T'(sat_val);
    end
  end

endmodule

// File: rtl/fc_par_relu.sv
// Fully-connected layer engine: buffers x, runs M/P groups of P parallel row dot-products, drains results.
module fc_par_relu
  import fc_par_pkg::*;
#(
  parameter int M    = 8,
  parameter int N    = 8,
  parameter int T    = 16,
  parameter int P    = 2,
  parameter int RELU = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       input_valid,
  output logic                       input_ready,
  input  logic signed [T-1:0]        input_data,
  output logic                       output_valid,
  input  logic                       output_ready,
  output logic signed [T-1:0]        output_data,
  input  logic                       w_wr_en,
  input  logic [$clog2(M*N)-1:0]     w_addr,
  input  logic signed [T-1:0]        w_data
);

  localparam int G  = M / P;
  localparam int BD = G * N;
  localparam int BW = (BD > 1) ? $clog2(BD) : 1;
  localparam int XW = $clog2(N);
  localparam int CW = $clog2(N + 1);
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam int PW = (P > 1) ? $clog2(P) : 1;

  state_t                state_reg;
  logic [CW-1:0]         cnt_reg;
  logic [GW-1:0]         g_reg;
  logic [PW-1:0]         lane_reg;

  logic signed [T-1:0]   x_mem [N];
  logic signed [T-1:0]   x_rd_reg;
  logic signed [T-1:0]   lane_res [P];

  logic [XW-1:0]         rd_k;
  logic [BW-1:0]         rd_addr;
  logic [BW-1:0]         w_laddr;
  int                    w_bank;
  logic                  w_ok;
  logic                  accept;
  logic                  compute_en;
  logic                  compute_clr;
  logic                  compute_last;
  logic                  last_group;
  logic                  last_lane;

  assign input_ready  = (state_reg == ST_LOAD);
  assign output_valid = (state_reg == ST_DRAIN);
  assign accept       = input_valid && input_ready;
  assign output_data  = output_valid ? lane_res[lane_reg] : '0;

  assign compute_en   = (state_reg == ST_COMPUTE) && (cnt_reg != '0);
  assign compute_clr  = (cnt_reg == CW'(1));
  assign compute_last = (cnt_reg == CW'(N));
  assign last_group   = (g_reg == GW'(G - 1));
  assign last_lane    = (lane_reg == PW'(P - 1));

  // Read index is held in range on the final compute cycle, whose read data is unused.
  always_comb begin
    int kk;
    int wm;
    int wn;
    kk      = (int'(cnt_reg) < N) ? int'(cnt_reg) : 0;
    rd_k    = XW'(kk);
    rd_addr = BW'(int'(g_reg) * N + kk);
    wm      = int'(w_addr) / N;
    wn      = int'(w_addr) % N;
    w_bank  = wm % P;
    w_laddr = BW'((wm / P) * N + wn);
    w_ok    = w_wr_en && (state_reg == ST_LOAD) && (int'(w_addr) < M * N);
  end

  always_ff @(posedge clk) begin
    if (accept) x_mem[cnt_reg[XW-1:0]] <= input_data;
    x_rd_reg <= x_mem[rd_k];
  end

  // Bank gi holds rows m with m mod P == gi, so one group's P rows are read in parallel.
  for (genvar gi = 0; gi < P; gi++) begin : g_lane
    logic signed [T-1:0] bank_mem [BD];
    logic signed [T-1:0] w_rd_reg;

    always_ff @(posedge clk) begin
      if (w_ok && w_bank == gi) bank_mem[w_laddr] <= w_data;
      w_rd_reg <= bank_mem[rd_addr];
    end

    fc_mac_lane #(
      .T    (T),
      .N    (N),
      .RELU (RELU)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .x      (x_rd_reg),
      .w      (w_rd_reg),
      .en     (compute_en),
      .clr    (compute_clr),
      .last   (compute_last),
      .result (lane_res[gi])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_LOAD;
      cnt_reg   <= '0;
      g_reg     <= '0;
      lane_reg  <= '0;
    end else begin
      case (state_reg)
        ST_LOAD: begin
          if (accept) begin
            if (cnt_reg == CW'(N - 1)) begin
              state_reg <= ST_COMPUTE;
              cnt_reg   <= '0;
              g_reg     <= '0;
            end else begin
              cnt_reg <= cnt_reg + CW'(1);
            end
          end
        end
        ST_COMPUTE: begin
          if (compute_last) begin
            state_reg <= ST_DRAIN;
            cnt_reg   <= '0;
            lane_reg  <= '0;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        ST_DRAIN: begin
          if (output_ready) begin
            if (last_lane) begin
              lane_reg <= '0;
              if (last_group) begin
                state_reg <= ST_LOAD;
                g_reg     <= '0;
              end else begin
                state_reg <= ST_COMPUTE;
                g_reg     <= g_reg + GW'(1);
              end
            end else begin
              lane_reg <= lane_reg + PW'(1);
            end
          end
        end
        default: state_reg <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_par_relu.sv
// Scoreboard bench: plain and ReLU engines run in lockstep against an integer matrix-vector model.
module tb_fc_par_relu;

  localparam int M  = 4;
  localparam int N  = 3;
  localparam int T  = 8;
  localparam int P  = 2;
  localparam int AW = $clog2(M * N);

  typedef struct {
    int y0;
    int y1;
  } exp_t;

  logic                 clk;
  logic                 reset;
  logic                 input_valid;
  logic signed [T-1:0]  input_data;
  logic                 output_ready;
  logic                 w_wr_en;
  logic [AW-1:0]        w_addr;
  logic signed [T-1:0]  w_data;
  logic                 ir0, ir1, ov0, ov1;
  logic signed [T-1:0]  od0, od1;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  int   w_sh[M*N];
  int   basic_w[M*N];
  int   vx[N];
  int   pops = 0;
  int   rdy_mode = 0;
  int   stall_left = 0;

  fc_par_relu #(.M(M), .N(N), .T(T), .P(P), .RELU(0)) u_dut0 (
    .clk(clk), .reset(reset), .input_valid(input_valid), .input_ready(ir0),
    .input_data(input_data), .output_valid(ov0), .output_ready(output_ready),
    .output_data(od0), .w_wr_en(w_wr_en), .w_addr(w_addr), .w_data(w_data)
  );

  fc_par_relu #(.M(M), .N(N), .T(T), .P(P), .RELU(1)) u_dut1 (
    .clk(clk), .reset(reset), .input_valid(input_valid), .input_ready(ir1),
    .input_data(input_data), .output_valid(ov1), .output_ready(output_ready),
    .output_data(od1), .w_wr_en(w_wr_en), .w_addr(w_addr), .w_data(w_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Output-ready driver: always ready, random, or held low; stall_left forces a low window.
  always @(posedge clk) begin
    #1;
    if (stall_left > 0) begin
      output_ready = 1'b0;
      stall_left--;
    end else if (rdy_mode == 1) output_ready = 1'($urandom_range(0, 1));
    else if (rdy_mode == 2) output_ready = 1'b0;
    else output_ready = 1'b1;
  end

  // Monitor: captures accepted x, pushes model results, checks latency, holds and pops.
  int  xcap[N];
  int  in_cnt = 0;
  int  cyc_n = 0;
  int  acc_edge = 0;
  bit  lat_pend = 0;
  bit  prev_valid = 0;
  bit  hold_pend = 0;

  always @(negedge clk) begin
    cyc_n++;
    if (reset) begin
      exp_q.delete();
      in_cnt = 0;
      lat_pend = 0;
      prev_valid = 0;
      hold_pend = 0;
    end else begin
      if (input_valid && ir0) begin
        xcap[in_cnt] = int'(input_data);
        in_cnt++;
        if (in_cnt == N) begin
          for (int m = 0; m < M; m++) begin
            int s;
            exp_t e;
            s = 0;
            for (int n = 0; n < N; n++) s += w_sh[m*N+n] * xcap[n];
            if (s > 127) s = 127;
            if (s < -128) s = -128;
            e.y0 = s;
            e.y1 = (s < 0) ? 0 : s;
            exp_q.push_back(e);
          end
          in_cnt = 0;
          acc_edge = cyc_n + 1;
          lat_pend = 1;
        end
      end
      if (ov0 && !prev_valid && lat_pend) begin
        chk("latency", cyc_n - acc_edge, N + 1);
        lat_pend = 0;
      end
      if (hold_pend) chk("hold_valid", int'(ov0), 1);
      hold_pend = 0;
      if (ov0 || ov1) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", int'(ov0) + int'(ov1), 0);
        end else begin
          chk("valid_relu", int'(ov1), int'(ov0));
          if (output_ready) begin
            exp_t e;
            e = exp_q.pop_front();
            pops++;
            chk("y_plain", int'(od0), e.y0);
            chk("y_relu", int'(od1), e.y1);
          end else begin
            chk("hold_data", int'(od0), exp_q[0].y0);
            hold_pend = 1;
          end
        end
      end
      prev_valid = ov0;
    end
  end

  task automatic write_w(input int a, input int v);
    w_wr_en = 1'b1;
    w_addr  = AW'(a);
    w_data  = T'(v);
    @(posedge clk); #1;
    w_wr_en = 1'b0;
    w_sh[a] = v;
  endtask

  // Loads vx; optional one-cycle-off gaps and an optional weight write alongside x[0].
  task automatic load_vec(input bit gaps, input bit do_w, input int wa, input int wd);
    for (int i = 0; i < N; i++) begin
      int t;
      if (gaps) begin
        input_valid = 1'b0;
        @(posedge clk); #1;
      end
      input_valid = 1'b1;
      input_data  = T'(vx[i]);
      if (do_w && i == 0) begin
        w_wr_en = 1'b1;
        w_addr  = AW'(wa);
        w_data  = T'(wd);
        w_sh[wa] = wd;
      end
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!ir0 && t < 1000);
      if (t >= 1000) chk("input_ready_timeout", t, 0);
      @(posedge clk); #1;
      input_valid = 1'b0;
      w_wr_en = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    checks++;
    if (t >= 2000) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d required=<2000", t);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int t;
    int p0;
    basic_w = '{1, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 1};
    reset = 1'b1;
    input_valid = 1'b0;
    input_data = '0;
    output_ready = 1'b1;
    w_wr_en = 1'b0;
    w_addr = '0;
    w_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(ov0), 0);
    chk("rst_ready", int'(ir0), 1);
    chk("rst_data", int'(od0), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", int'(ir0) + int'(ir1), 2);
    chk("post_rst_valid", int'(ov0) + int'(ov1), 0);

    // Basic: last weight written in the same cycle as x[0] is accepted.
    for (int a = 0; a < M*N - 1; a++) write_w(a, basic_w[a]);
    vx = '{3, -4, 5};
    load_vec(0, 1, M*N - 1, basic_w[M*N-1]);
    wait_idle();

    // Gapped input and a 5-cycle stall while y[1] is presented.
    p0 = pops;
    load_vec(1, 0, 0, 0);
    t = 0;
    while (pops != p0 + 1 && t < 200) begin
      @(posedge clk);
      t++;
    end
    if (t >= 200) chk("bp_timeout", t, 0);
    stall_left = 5;
    wait_idle();
    chk("bp_count", pops - p0, M);

    // Saturation, both polarities.
    for (int a = 0; a < M*N; a++) write_w(a, 127);
    vx = '{127, 127, 127};
    load_vec(0, 0, 0, 0);
    wait_idle();
    for (int a = 0; a < M*N; a++) write_w(a, -128);
    load_vec(0, 0, 0, 0);
    wait_idle();

    // Reset during compute cycle 2, then a fresh vector on the retained weights.
    for (int a = 0; a < M*N; a++) write_w(a, basic_w[a]);
    vx = '{3, -4, 5};
    load_vec(0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("midrst_valid", int'(ov0) + int'(ov1), 0);
    chk("midrst_ready", int'(ir0) + int'(ir1), 2);
    @(posedge clk); #1;
    reset = 1'b0;
    p0 = pops;
    vx = '{1, 1, 1};
    load_vec(0, 0, 0, 0);
    wait_idle();
    chk("midrst_count", pops - p0, M);

    // Weight write during drain must be ignored.
    rdy_mode = 2;
    vx = '{3, -4, 5};
    load_vec(0, 0, 0, 0);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!ov0 && t < 100);
    if (t >= 100) chk("lockout_timeout", t, 0);
    @(posedge clk); #1;
    w_wr_en = 1'b1;
    w_addr  = '0;
    w_data  = 8'sd9;
    @(posedge clk); #1;
    w_wr_en = 1'b0;
    rdy_mode = 0;
    wait_idle();
    load_vec(0, 0, 0, 0);
    wait_idle();

    // Randomised vectors, weights, gaps and backpressure.
    rdy_mode = 1;
    for (int v = 0; v < 15; v++) begin
      for (int k = 0; k < 3; k++)
        write_w(int'($urandom_range(0, M*N - 1)), int'($urandom_range(0, 255)) - 128);
      for (int i = 0; i < N; i++) vx[i] = int'($urandom_range(0, 255)) - 128;
      load_vec(1'($urandom_range(0, 1)), 0, 0, 0);
      wait_idle();
    end
    rdy_mode = 0;
    wait_idle();
    chk("leftover", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
